// File: rtl/jt10_adpcm_pkg.sv
// Shared constants, ROM FSM state type and channel-index helpers for the
// ADPCM ROM reader.
package jt10_adpcm_pkg;

   localparam int AW  = 25;
   localparam int NCH = 6;
   localparam int CHW = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } rom_state_t;

   // Lowest set bit wins, so the same function serves as the fetch priority encoder.
   function automatic logic [CHW-1:0] oh2idx(input logic [NCH-1:0] oh);
      logic [CHW-1:0] idx;
      idx = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (oh[i]) idx = CHW'(i);
      end
      return idx;
   endfunction

   function automatic logic is_onehot(input logic [NCH-1:0] v);
      return (v != '0) && ((v & (v - NCH'(1))) == '0);
   endfunction

endpackage

// File: rtl/jt10_adpcm_romfsm.sv
// Single-request ROM handshake: picks the lowest pending channel, holds the
// address until rom_ok, then spends one clock in IDLE before the next fetch.
module jt10_adpcm_romfsm
   import jt10_adpcm_pkg::*;
#(
   parameter int AW  = jt10_adpcm_pkg::AW,
   parameter int NCH = jt10_adpcm_pkg::NCH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NCH-1:0]         pend,
   input  logic [NCH-1:0][AW-1:0] pend_tag,
   input  logic                   rom_ok,
   output logic [AW-1:0]          rom_addr,
   output logic                   rom_cs,
   output logic                   grant,
   output logic [CHW-1:0]         grant_ch,
   output logic                   busy,
   output logic [CHW-1:0]         busy_ch,
   output logic                   fill
);

   rom_state_t     state_q, state_d;
   logic [AW-1:0]  rom_addr_q, rom_addr_d;
   logic           rom_cs_q, rom_cs_d;
   logic [CHW-1:0] ch_q, ch_d;

   always_comb begin
      grant      = (state_q == ST_IDLE) && (pend != '0);
      grant_ch   = oh2idx(pend);
      fill       = (state_q == ST_BUSY) && rom_ok;
      state_d    = state_q;
      rom_addr_d = rom_addr_q;
      rom_cs_d   = rom_cs_q;
      ch_d       = ch_q;
      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               state_d    = ST_BUSY;
               rom_addr_d = pend_tag[grant_ch];
               rom_cs_d   = 1'b1;
               ch_d       = grant_ch;
            end
         end
         ST_BUSY: begin
            if (rom_ok) begin
               state_d  = ST_IDLE;
               rom_cs_d = 1'b0;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            rom_cs_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rom_addr_q <= '0;
         rom_cs_q   <= 1'b0;
         ch_q       <= '0;
      end else begin
         state_q    <= state_d;
         rom_addr_q <= rom_addr_d;
         rom_cs_q   <= rom_cs_d;
         ch_q       <= ch_d;
      end
   end

   assign rom_addr = rom_addr_q;
   assign rom_cs   = rom_cs_q;
   assign busy     = (state_q == ST_BUSY);
   assign busy_ch  = ch_q;

endmodule

// File: rtl/jt10_adpcm_romrd.sv
// ADPCM ROM reader: one cached byte per channel with next-byte prefetch,
// all channels sharing one ROM request port.
module jt10_adpcm_romrd
   import jt10_adpcm_pkg::*;
#(
   parameter int AW  = jt10_adpcm_pkg::AW,
   parameter int NCH = jt10_adpcm_pkg::NCH
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           cen,
   input  logic [NCH-1:0] cur_ch,
   input  logic [19:0]    addr,
   input  logic [4:0]     bank,
   input  logic           sel,
   input  logic           roe_n,
   input  logic           clr,
   output logic [AW-1:0]  rom_addr,
   output logic           rom_cs,
   input  logic [7:0]     rom_data,
   input  logic           rom_ok,
   output logic [3:0]     nibble,
   output logic [2:0]     nib_ch,
   output logic           nib_vld,
   output logic           miss
);

   logic [NCH-1:0]         valid_q, valid_d;
   logic [NCH-1:0][AW-1:0] tag_q, tag_d;
   logic [NCH-1:0][7:0]    data_q, data_d;
   logic [NCH-1:0]         pend_q, pend_d;
   logic [NCH-1:0][AW-1:0] pend_tag_q, pend_tag_d;
   logic                   abort_q, abort_d;
   logic [3:0]             nibble_q, nibble_d;
   logic [2:0]             nib_ch_q, nib_ch_d;
   logic                   nib_vld_q, nib_vld_d;
   logic                   miss_q, miss_d;

   logic           grant, busy, fill;
   logic [CHW-1:0] grant_ch, busy_ch;
   logic [AW-1:0]  req_addr;
   logic [CHW-1:0] k;
   logic           slot, do_clr, do_req, hit, inflight, clr_busy, clr_grant;

   assign req_addr = AW'({bank, addr});

   always_comb begin
      k        = oh2idx(cur_ch);
      slot     = cen && is_onehot(cur_ch);
      do_clr   = slot && clr;
      do_req   = slot && !clr && !roe_n;
      hit      = valid_q[k] && (tag_q[k] == req_addr);
      // A fetch for this very byte already under way (or starting now) needs no new pend
      inflight = (busy && (busy_ch == k) && (rom_addr == req_addr)) ||
                 (grant && (grant_ch == k) && (pend_tag_q[k] == req_addr));
      clr_busy  = do_clr && busy && (busy_ch == k);
      clr_grant = do_clr && grant && (grant_ch == k);

      valid_d    = valid_q;
      tag_d      = tag_q;
      data_d     = data_q;
      pend_d     = pend_q;
      pend_tag_d = pend_tag_q;
      abort_d    = abort_q;
      nibble_d   = nibble_q;
      nib_ch_d   = nib_ch_q;
      nib_vld_d  = 1'b0;
      miss_d     = 1'b0;

      if (grant) pend_d[grant_ch] = 1'b0;

      if (do_clr) begin
         valid_d[k] = 1'b0;
         pend_d[k]  = 1'b0;
      end else if (do_req) begin
         nib_vld_d = 1'b1;
         nib_ch_d  = k;
         if (hit) begin
            nibble_d = sel ? data_q[k][3:0] : data_q[k][7:4];
            if (sel) begin
               pend_d[k]     = 1'b1;
               pend_tag_d[k] = req_addr + AW'(1);
            end
         end else begin
            nibble_d   = 4'd0;
            miss_d     = 1'b1;
            valid_d[k] = 1'b0;
            if (!inflight) begin
               pend_d[k]     = 1'b1;
               pend_tag_d[k] = req_addr;
            end
         end
      end

      if (grant)         abort_d = clr_grant;
      else if (fill)     abort_d = 1'b0;
      else if (clr_busy) abort_d = 1'b1;

      // Fill is applied last so it overrides a same-edge miss invalidation
      if (fill && !abort_q && !clr_busy) begin
         valid_d[busy_ch] = 1'b1;
         tag_d[busy_ch]   = rom_addr;
         data_d[busy_ch]  = rom_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= '0;
         tag_q      <= '0;
         data_q     <= '0;
         pend_q     <= '0;
         pend_tag_q <= '0;
         abort_q    <= 1'b0;
         nibble_q   <= '0;
         nib_ch_q   <= '0;
         nib_vld_q  <= 1'b0;
         miss_q     <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         tag_q      <= tag_d;
         data_q     <= data_d;
         pend_q     <= pend_d;
         pend_tag_q <= pend_tag_d;
         abort_q    <= abort_d;
         nibble_q   <= nibble_d;
         nib_ch_q   <= nib_ch_d;
         nib_vld_q  <= nib_vld_d;
         miss_q     <= miss_d;
      end
   end

   jt10_adpcm_romfsm #(
      .AW  (AW),
      .NCH (NCH)
   ) u_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .pend     (pend_q),
      .pend_tag (pend_tag_q),
      .rom_ok   (rom_ok),
      .rom_addr (rom_addr),
      .rom_cs   (rom_cs),
      .grant    (grant),
      .grant_ch (grant_ch),
      .busy     (busy),
      .busy_ch  (busy_ch),
      .fill     (fill)
   );

   assign nibble  = nibble_q;
   assign nib_ch  = nib_ch_q;
   assign nib_vld = nib_vld_q;
   assign miss    = miss_q;

endmodule

// File: tb/tb_jt10_adpcm_romrd.sv
// Directed bench for the ADPCM ROM reader: stimulus pushes expected nibbles and
// ROM addresses into queues, a negedge monitor pops and compares them.
module tb_jt10_adpcm_romrd;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cen = 1'b0;
   logic [5:0]  cur_ch = '0;
   logic [19:0] addr = '0;
   logic [4:0]  bank = '0;
   logic        sel = 1'b0;
   logic        roe_n = 1'b1;
   logic        clr = 1'b0;
   logic [24:0] rom_addr;
   logic        rom_cs;
   logic [7:0]  rom_data = '0;
   logic        rom_ok = 1'b0;
   logic [3:0]  nibble;
   logic [2:0]  nib_ch;
   logic        nib_vld;
   logic        miss;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [3:0] nib;
      logic [2:0] ch;
      logic       miss;
   } nib_t;

   nib_t        nib_q[$];
   logic [24:0] addr_q[$];
   nib_t        mon_e;
   logic [24:0] mon_a;
   logic        cs_prev = 1'b0;

   jt10_adpcm_romrd dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cen      (cen),
      .cur_ch   (cur_ch),
      .addr     (addr),
      .bank     (bank),
      .sel      (sel),
      .roe_n    (roe_n),
      .clr      (clr),
      .rom_addr (rom_addr),
      .rom_cs   (rom_cs),
      .rom_data (rom_data),
      .rom_ok   (rom_ok),
      .nibble   (nibble),
      .nib_ch   (nib_ch),
      .nib_vld  (nib_vld),
      .miss     (miss)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Monitor: every nibble strobe and every rising rom_cs is one transaction
   always @(negedge clk) begin
      if (nib_vld) begin
         if (nib_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL nib_unexpected: got ch=%0d nib=%h miss=%b, required no output",
                     nib_ch, nibble, miss);
         end else begin
            mon_e = nib_q.pop_front();
            chk("nib{nib,ch,miss}", 64'({nibble, nib_ch, miss}), 64'(mon_e));
         end
      end
      if (rom_cs && !cs_prev) begin
         if (addr_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rom_unexpected: got rom_addr=%h, required no fetch", rom_addr);
         end else begin
            mon_a = addr_q.pop_front();
            chk("rom_addr", 64'(rom_addr), 64'(mon_a));
         end
      end
      cs_prev <= rom_cs;
   end

   task automatic req(input int ch, input logic [24:0] a, input logic s, input logic c);
      @(negedge clk);
      cen    = 1'b1;
      cur_ch = 6'(1 << ch);
      {bank, addr} = a;
      sel    = s;
      roe_n  = 1'b0;
      clr    = c;
      @(negedge clk);
      cen    = 1'b0;
      cur_ch = '0;
      roe_n  = 1'b1;
      clr    = 1'b0;
   endtask

   task automatic exp_nib(input logic [3:0] n, input logic [2:0] ch, input logic m);
      nib_t e;
      e.nib  = n;
      e.ch   = ch;
      e.miss = m;
      nib_q.push_back(e);
   endtask

   task automatic wait_cs(input string name);
      int n = 0;
      while (!rom_cs && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!rom_cs) begin
         bad++;
         $display("FAIL %s: rom_cs=0 after 50 clk, required 1", name);
      end else begin
         $display("ok   %s: rom_cs up at %h", name, rom_addr);
      end
   endtask

   // ROM responder: hold for dly clocks (address must stay put), then one rom_ok pulse
   task automatic complete(input string name, input logic [7:0] d, input int dly);
      logic [24:0] a0;
      a0 = rom_addr;
      for (int i = 0; i < dly; i++) begin
         @(negedge clk);
         chk({name, "_hold"}, 64'({rom_cs, rom_addr}), 64'({1'b1, a0}));
      end
      rom_data = d;
      rom_ok   = 1'b1;
      @(negedge clk);
      rom_ok   = 1'b0;
      rom_data = '0;
      chk({name, "_cs_drop"}, 64'(rom_cs), 64'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_outs", 64'({rom_cs, rom_addr, nibble, nib_ch, nib_vld, miss}), 64'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Non-one-hot channel: nothing may happen
      cen = 1'b1; cur_ch = 6'b000101; roe_n = 1'b0; {bank, addr} = 25'h0000010;
      @(negedge clk);
      cen = 1'b0; cur_ch = '0; roe_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("non_onehot_cs", 64'(rom_cs), 64'(0));

      // Cold miss, fill, then both nibbles hit
      exp_nib(4'h0, 3'd0, 1'b1); addr_q.push_back(25'h0001234);
      req(0, 25'h0001234, 1'b0, 1'b0);
      wait_cs("cold_cs");
      complete("cold", 8'hA5, 2);
      exp_nib(4'hA, 3'd0, 1'b0);
      req(0, 25'h0001234, 1'b0, 1'b0);
      exp_nib(4'h5, 3'd0, 1'b0); addr_q.push_back(25'h0001235);
      req(0, 25'h0001234, 1'b1, 1'b0);
      wait_cs("pref_cs");
      complete("pref", 8'h3C, 1);
      exp_nib(4'h3, 3'd0, 1'b0);
      req(0, 25'h0001235, 1'b0, 1'b0);

      // Address wrap on prefetch
      exp_nib(4'h0, 3'd3, 1'b1); addr_q.push_back(25'h1FFFFFF);
      req(3, 25'h1FFFFFF, 1'b1, 1'b0);
      wait_cs("wrap_miss_cs");
      complete("wrap_miss", 8'h7E, 1);
      exp_nib(4'hE, 3'd3, 1'b0); addr_q.push_back(25'h0000000);
      req(3, 25'h1FFFFFF, 1'b1, 1'b0);
      wait_cs("wrap_pref_cs");
      complete("wrap_pref", 8'h11, 1);
      exp_nib(4'h1, 3'd3, 1'b0);
      req(3, 25'h0000000, 1'b0, 1'b0);

      // Priority: ch4 and ch1 queue up behind a ch5 fetch; ch1 must go first
      exp_nib(4'h0, 3'd5, 1'b1); addr_q.push_back(25'h0000500);
      req(5, 25'h0000500, 1'b0, 1'b0);
      wait_cs("ch5_cs");
      exp_nib(4'h0, 3'd4, 1'b1);
      req(4, 25'h0000400, 1'b0, 1'b0);
      exp_nib(4'h0, 3'd1, 1'b1);
      req(1, 25'h0000100, 1'b0, 1'b0);
      addr_q.push_back(25'h0000100);
      addr_q.push_back(25'h0000400);
      complete("ch5", 8'h50, 1);
      wait_cs("ch1_cs");
      complete("ch1", 8'h96, 10);
      wait_cs("ch4_cs");
      complete("ch4", 8'h44, 1);
      exp_nib(4'h4, 3'd4, 1'b0);
      req(4, 25'h0000400, 1'b0, 1'b0);
      exp_nib(4'h9, 3'd1, 1'b0);
      req(1, 25'h0000100, 1'b0, 1'b0);

      // Abort: clr while ch2 fetch is in flight discards the fill
      exp_nib(4'h0, 3'd2, 1'b1); addr_q.push_back(25'h0000200);
      req(2, 25'h0000200, 1'b0, 1'b0);
      wait_cs("abort_cs");
      req(2, 25'h0000200, 1'b0, 1'b1);
      complete("abort", 8'h55, 2);
      exp_nib(4'h0, 3'd2, 1'b1); addr_q.push_back(25'h0000200);
      req(2, 25'h0000200, 1'b0, 1'b0);
      wait_cs("refetch_cs");
      complete("refetch", 8'h66, 1);
      exp_nib(4'h6, 3'd2, 1'b0);
      req(2, 25'h0000200, 1'b0, 1'b0);

      // Reset in the middle of a fetch
      exp_nib(4'h0, 3'd0, 1'b1); addr_q.push_back(25'h0000777);
      req(0, 25'h0000777, 1'b0, 1'b0);
      wait_cs("rst_fetch_cs");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_outs", 64'({rom_cs, rom_addr, nibble, nib_ch, nib_vld, miss}), 64'(0));
      rom_data = 8'hFF;
      rom_ok   = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rom_ok   = 1'b0;
      rom_data = '0;
      repeat (2) @(negedge clk);
      chk("rst_late_ok_cs", 64'(rom_cs), 64'(0));
      exp_nib(4'h0, 3'd0, 1'b1); addr_q.push_back(25'h0001235);
      req(0, 25'h0001235, 1'b0, 1'b0);
      wait_cs("post_rst_cs");
      complete("post_rst", 8'h3C, 1);

      repeat (5) @(negedge clk);
      chk("nib_queue_left", 64'(nib_q.size()), 64'(0));
      chk("addr_queue_left", 64'(addr_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
